uart_stim_tx: RTL and testbench
===============================

UART_STIM_TX -- requirements
Module: uart_stim_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning data bits per frame (legal 5..9).
REQ-002 SHALL have parameter DIV_W, default 16, meaning width of the bit-period divisor input.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning transmit FIFO entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-006 SHALL have port wr_en_i  input  1  push wr_data_i into FIFO this cycle.
REQ-007 SHALL have port wr_data_i  input  DATA_W  frame payload.
REQ-008 SHALL have port div_i  input  DIV_W  bit period = div_i+1 clk cycles.
REQ-009 SHALL have port parity_i  input  2  00/11 none, 01 even, 10 odd.
REQ-010 SHALL have port stop2_i  input  1  1 = two stop bits, 0 = one.
REQ-011 SHALL have port tx_o  output  1  serial line, idle high.
REQ-012 SHALL have port busy_o  output  1  frame in progress.
REQ-013 SHALL have port full_o  output  1  FIFO full.
REQ-014 SHALL have port empty_o  output  1  FIFO empty.
REQ-015 SHALL have port level_o  output  clog2(FIFO_DEPTH)+1  FIFO occupancy.

Function
REQ-016 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE: tx_o=1, busy_o=0; when FIFO non-empty, SHALL pop head and enter START next cycle.
REQ-018 On leaving IDLE SHALL latch div_i, parity_i, stop2_i and the popped word; changes to these inputs mid-frame SHALL NOT affect the current frame.
REQ-019 Each bit state SHALL hold tx_o for exactly div_latched+1 cycles via a down-counter reloaded on every bit boundary.
REQ-020 START: tx_o=0, then DATA.
REQ-021 DATA: SHALL shift DATA_W bits LSB first, then PARITY if parity enabled else STOP.
REQ-022 PARITY: tx_o = XOR of data bits (even) or its inverse (odd).
REQ-023 STOP: tx_o=1 for one or two bit periods per stop2_latched; then, if FIFO non-empty, pop and go directly to START (no idle gap), else IDLE.
REQ-024 busy_o SHALL be 1 in START, DATA, PARITY, STOP.
REQ-025 Latency: wr_en_i into empty FIFO while IDLE at cycle N SHALL drive tx_o low at cycle N+2.
REQ-026 wr_en_i while full_o=1 SHALL be dropped; FIFO contents and level_o unchanged.
REQ-027 Simultaneous push and pop SHALL leave level_o unchanged and accept the pushed word, including when full (pop frees the slot first).
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full_o = (level_o==FIFO_DEPTH), empty_o = (level_o==0).
REQ-029 div_i=0 SHALL give one-cycle bits; no other divisor value is special.

Reset
REQ-030 While rst=1 SHALL force IDLE, tx_o=1, busy_o=0, empty_o=1, full_o=0, level_o=0, counters and pointers 0, immediately (asynchronous).
REQ-031 rst asserted mid-frame SHALL abort the frame and discard all FIFO contents; first frame after release SHALL only start from a new push.

Verification
REQ-032 div_i=7, parity none, stop2=0, push 0x55 -> tx_o low 8 cycles, then 1,0,1,0,1,0,1,0 each 8 cycles, high 8 cycles, busy_o low after 80 cycles total.
REQ-033 div_i=7, parity even, push 0x07 -> parity bit 1 for 8 cycles after data; parity odd -> 0.
REQ-034 Push 0xA5,0x3C,0xFF,0x00,0x11 back-to-back with FIFO_DEPTH=4 while IDLE -> first pops immediately, remaining four fill FIFO, full_o=1, no word dropped; frames emitted contiguous with no idle gap.
REQ-035 FIFO full and one push coincident with a STOP->START pop -> push accepted, level_o stays 4.
REQ-036 stop2_i=1, div_i=0 -> stop phase exactly 2 cycles high; change div_i mid-frame -> current frame timing unchanged.
REQ-037 Assert rst during DATA with 2 words queued -> tx_o=1, level_o=0 same cycle; after release tx_o stays 1 until next push.

Source files
------------

// File: rtl/uart_stim_tx.sv
// UART transmitter with a small transmit FIFO.
// Frame settings are captured per frame when the head word is popped.
module uart_stim_tx #(
  parameter int DATA_W     = 8,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en_i,
  input  logic [DATA_W-1:0]             wr_data_i,
  input  logic [DIV_W-1:0]              div_i,
  input  logic [1:0]                    parity_i,
  input  logic                          stop2_i,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [AW:0]       level_q;
  logic              push, pop;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_en_q, par_en_d;
  logic              pbit_q, pbit_d;
  logic              stop2_q, stop2_d;
  logic              stop_q, stop_d;
  logic              tick;

  assign full_o  = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign push = wr_en_i && (!full_o || pop);

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      level_q <= level_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_en_q <= 1'b0;
      pbit_q   <= 1'b0;
      stop2_q  <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_en_q <= par_en_d;
      pbit_q   <= pbit_d;
      stop2_q  <= stop2_d;
      stop_q   <= stop_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_en_d = par_en_q;
    pbit_d   = pbit_q;
    stop2_d  = stop2_q;
    stop_d   = stop_q;
    pop      = 1'b0;
    tick     = (cnt_q == '0);
    unique case (state_q)
      IDLE: pop = !empty_o;
      START: begin
        if (tick) begin
          state_d = DATA;
          cnt_d   = div_q;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      DATA: begin
        if (tick) begin
          cnt_d = div_q;
          if (bit_q == LAST) begin
            state_d = par_en_q ? PARITY : STOP;
            stop_d  = 1'b0;
          end else begin
            bit_d   = bit_q + BW'(1);
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          cnt_d   = div_q;
          stop_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      STOP: begin
        if (!tick) begin
          cnt_d = cnt_q - DIV_W'(1);
        end else if (stop2_q && !stop_q) begin
          stop_d = 1'b1;
          cnt_d  = div_q;
        end else if (!empty_o) begin
          pop = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Popping the head starts a frame and captures its settings
    if (pop) begin
      state_d  = START;
      cnt_d    = div_i;
      div_d    = div_i;
      shift_d  = mem_q[rptr_q];
      par_en_d = ^parity_i;
      pbit_d   = (^mem_q[rptr_q]) ^ (parity_i == 2'b10);
      stop2_d  = stop2_i;
      stop_d   = 1'b0;
    end
  end

  always_comb begin
    tx_o = 1'b1;
    unique case (state_q)
      START:   tx_o = 1'b0;
      DATA:    tx_o = shift_q[0];
      PARITY:  tx_o = pbit_q;
      default: tx_o = 1'b1;
    endcase
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_uart_stim_tx.sv
// Scoreboard bench for uart_stim_tx: stimulus queues expected frames,
// a line monitor decodes tx_o bit by bit against them.
module tb_uart_stim_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic [15:0] div = '0;
  logic [1:0] par = '0;
  logic       stop2 = 1'b0;
  logic       tx, busy, full, empty;
  logic [2:0] level;

  typedef struct {
    logic [7:0] data;
    int         div;
    logic [1:0] par;
    logic       stop2;
  } frame_t;

  frame_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int frames = 0;

  uart_stim_tx #(.DATA_W(8), .DIV_W(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .wr_en_i(wr_en), .wr_data_i(wr_data),
    .div_i(div), .parity_i(par), .stop2_i(stop2),
    .tx_o(tx), .busy_o(busy), .full_o(full),
    .empty_o(empty), .level_o(level)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input bit expect_it);
    wr_en = 1'b1;
    wr_data = d;
    if (expect_it)
      exp_q.push_back('{data: d, div: int'(div), par: par, stop2: stop2});
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 3000; i++) begin
      if (!busy && empty) break;
      step();
    end
    chk(name, {30'd0, busy, empty}, 32'd1);
  endtask

  // Line monitor: a low level on an idle line starts the next expected frame
  initial begin : monitor
    frame_t f;
    bit     vals[$];
    bit     abort;
    bit     bad;
    forever begin
      @(negedge clk);
      if (rst || tx !== 1'b0) continue;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got start bit expected idle line");
        continue;
      end
      f = exp_q.pop_front();
      vals.delete();
      vals.push_back(1'b0);
      for (int i = 0; i < 8; i++) vals.push_back(f.data[i]);
      if (f.par == 2'b01 || f.par == 2'b10)
        vals.push_back((^f.data) ^ (f.par == 2'b10));
      vals.push_back(1'b1);
      if (f.stop2) vals.push_back(1'b1);
      abort = 1'b0;
      for (int b = 0; b < vals.size() && !abort; b++) begin
        bad = 1'b0;
        for (int c = 0; c <= f.div; c++) begin
          if (!(b == 0 && c == 0)) @(negedge clk);
          if (rst) begin
            abort = 1'b1;
            break;
          end
          if (tx !== vals[b] || busy !== 1'b1) bad = 1'b1;
        end
        if (!abort) begin
          checks++;
          if (bad) begin
            errors++;
            $display("FAIL frame%0d_bit%0d: got tx %0b busy %0b expected tx %0b data %0h",
                     frames, b, tx, busy, vals[b], f.data);
          end
        end
      end
      if (!abort) frames++;
    end
  end

  initial begin : stim
    int gap;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_level", level, 0);
    rst = 1'b0;
    step();
    step();

    // 0x55, div 7, no parity, one stop bit
    div = 16'd7;
    par = 2'b00;
    stop2 = 1'b0;
    push(8'h55, 1);
    chk("lat_idle_n1", tx, 1);
    step();
    chk("lat_start_n2", tx, 0);
    chk("lat_busy_n2", busy, 1);
    repeat (79) step();
    chk("busy_cycle80", busy, 1);
    step();
    chk("busy_after80", busy, 0);

    // parity bit for 0x07: even -> 1, odd -> 0
    par = 2'b01;
    push(8'h07, 1);
    repeat (73) step();
    chk("parity_even", tx, 1);
    wait_idle("idle_after_even");
    par = 2'b10;
    push(8'h07, 1);
    repeat (73) step();
    chk("parity_odd", tx, 0);
    wait_idle("idle_after_odd");
    par = 2'b00;

    // five back-to-back words, contiguous frames
    div = 16'd1;
    push(8'hA5, 1);
    push(8'h3C, 1);
    push(8'hFF, 1);
    push(8'h00, 1);
    push(8'h11, 1);
    chk("burst_full", full, 1);
    chk("burst_level", level, 4);
    gap = 0;
    for (int i = 0; i < 96; i++) begin
      step();
      if (busy !== 1'b1) gap++;
    end
    chk("burst_no_gap", gap, 0);
    step();
    chk("burst_end", busy, 0);
    wait_idle("idle_after_burst");

    // drop when full, accept when push meets STOP->START pop
    div = 16'd0;
    push(8'h12, 1);
    push(8'h34, 1);
    push(8'h56, 1);
    push(8'h78, 1);
    push(8'h9A, 1);
    push(8'hEE, 0);
    chk("drop_level", level, 4);
    chk("drop_full", full, 1);
    repeat (5) step();
    push(8'hC3, 1);
    chk("coinc_level", level, 4);
    chk("coinc_full", full, 1);
    wait_idle("idle_after_coinc");

    // two stop bits at div 0, divisor changed mid-frame
    stop2 = 1'b1;
    push(8'h81, 1);
    step();
    div = 16'd5;
    chk("s2_start", tx, 0);
    repeat (10) step();
    chk("s2_last_busy", busy, 1);
    chk("s2_last_tx", tx, 1);
    step();
    chk("s2_done", busy, 0);
    stop2 = 1'b0;
    wait_idle("idle_after_s2");

    // reset during DATA with two words queued
    div = 16'd3;
    push(8'h5A, 1);
    push(8'hC3, 1);
    push(8'h0F, 1);
    repeat (4) step();
    chk("pre_rst_level", level, 2);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_tx", tx, 1);
    chk("rst_mid_level", level, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_empty", empty, 1);
    exp_q.delete();
    repeat (3) step();
    rst = 1'b0;
    gap = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0) gap++;
    end
    chk("post_rst_idle", gap, 0);
    push(8'h3E, 1);
    wait_idle("idle_after_rst");

    repeat (2) step();
    chk("queue_drained", exp_q.size(), 0);
    chk("frames_seen", frames, 16);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
